// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversampled pins, valid/ready TX and RX streams, and a frame counter.
// Optional RX FIFO (first-word fall-through) when SPI_PERIPH_RX_FIFO_EN is defined.
module spi_peripheral #(
  parameter logic [7:0] FILL = 8'h00
`ifdef SPI_PERIPH_RX_FIFO_EN
  , parameter int unsigned RX_DEPTH = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic       i_clear,
  output logic [7:0] o_transac,
  output logic       o_rx_overrun,
  output logic       o_tx_underrun,
  output logic       o_abort
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_n;
  logic        sclk_s1, sclk_s2, sclk_s3;
  logic        cs_s1, cs_s2, cs_s3;
  logic        mosi_s1, mosi_s2;
  logic        miso_oe_q;
  logic [2:0]  bit_cnt_q, bit_cnt_n;
  logic [7:0]  rx_sr_q, rx_sr_n;
  logic [7:0]  tx_sr_q, tx_sr_n;
  logic [7:0]  hold_q, hold_n;
  logic        hold_empty_q, hold_empty_n;
  logic        miso_q, miso_n;
  logic [7:0]  transac_q, transac_n;
  logic        abort_q, abort_n;
  logic        underrun_q, underrun_n;
  logic        push_c, load_c;
  logic [7:0]  rx_byte_c;
  logic        sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;

  // Pin synchronizers; MOSI is used at s2 so it lines up with SCLK edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_s3     <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      sclk_s1   <= i_sclk;
      sclk_s2   <= sclk_s1;
      sclk_s3   <= sclk_s2;
      cs_s1     <= i_cs_n;
      cs_s2     <= cs_s1;
      cs_s3     <= cs_s2;
      mosi_s1   <= i_mosi;
      mosi_s2   <= mosi_s1;
      miso_oe_q <= ~cs_s1;
    end
  end

  assign sclk_rise_c = sclk_s2 & ~sclk_s3;
  assign sclk_fall_c = ~sclk_s2 & sclk_s3;
  assign cs_rise_c   = cs_s2 & ~cs_s3;
  assign cs_fall_c   = ~cs_s2 & cs_s3;

  // Next-state and datapath
  always_comb begin
    state_n      = state_q;
    bit_cnt_n    = bit_cnt_q;
    rx_sr_n      = rx_sr_q;
    tx_sr_n      = tx_sr_q;
    hold_n       = hold_q;
    hold_empty_n = hold_empty_q;
    transac_n    = transac_q;
    abort_n      = 1'b0;
    underrun_n   = 1'b0;
    push_c       = 1'b0;
    load_c       = 1'b0;
    rx_byte_c    = {rx_sr_q[6:0], mosi_s2};

    case (state_q)
      IDLE: begin
        bit_cnt_n = 3'd0;
        if (cs_fall_c) begin
          load_c  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise_c) begin
          state_n   = IDLE;
          bit_cnt_n = 3'd0;
          abort_n   = (bit_cnt_q != 3'd0);
        end else if (sclk_rise_c) begin
          rx_sr_n = rx_byte_c;
          if (bit_cnt_q == 3'd7) begin
            push_c    = 1'b1;
            load_c    = 1'b1;
            bit_cnt_n = 3'd0;
            transac_n = transac_q + 8'd1;
          end else begin
            bit_cnt_n = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall_c && (bit_cnt_q != 3'd0)) begin
          tx_sr_n = {tx_sr_q[6:0], 1'b0};
        end
      end
      default: state_n = IDLE;
    endcase

    // A load takes the pre-accept holding value, so a same-cycle accept is safe
    if (load_c) begin
      if (hold_empty_q) begin
        tx_sr_n    = FILL;
        underrun_n = 1'b1;
      end else begin
        tx_sr_n      = hold_q;
        hold_empty_n = 1'b1;
      end
    end
    if (i_tx_valid && hold_empty_q) begin
      hold_n       = i_tx_data;
      hold_empty_n = 1'b0;
    end
    if (i_clear) transac_n = 8'd0;
    miso_n = (state_n == SHIFT) & tx_sr_n[7];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      rx_sr_q      <= 8'd0;
      tx_sr_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_empty_q <= 1'b1;
      miso_q       <= 1'b0;
      transac_q    <= 8'd0;
      abort_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      bit_cnt_q    <= bit_cnt_n;
      rx_sr_q      <= rx_sr_n;
      tx_sr_q      <= tx_sr_n;
      hold_q       <= hold_n;
      hold_empty_q <= hold_empty_n;
      miso_q       <= miso_n;
      transac_q    <= transac_n;
      abort_q      <= abort_n;
      underrun_q   <= underrun_n;
    end
  end

  assign o_miso        = miso_q;
  assign o_miso_oe     = miso_oe_q;
  assign o_tx_ready    = hold_empty_q;
  assign o_transac     = transac_q;
  assign o_abort       = abort_q;
  assign o_tx_underrun = underrun_q;

`ifdef SPI_PERIPH_RX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(RX_DEPTH);

  logic [7:0]     mem [RX_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic           full_c, pop_c, wr_c, overrun_q;

  assign full_c = (count_q == (PTR_W+1)'(RX_DEPTH));
  assign pop_c  = (count_q != '0) & i_rx_ready;
  assign wr_c   = push_c & (~full_c | pop_c);

  always_ff @(posedge clk) begin
    if (wr_c) mem[wptr_q] <= rx_byte_c;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_c & full_c & ~pop_c;
      if (wr_c)  wptr_q <= wptr_q + PTR_W'(1);
      if (pop_c) rptr_q <= rptr_q + PTR_W'(1);
      if (wr_c && !pop_c)      count_q <= count_q + (PTR_W+1)'(1);
      else if (!wr_c && pop_c) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  assign o_rx_valid   = (count_q != '0);
  assign o_rx_data    = o_rx_valid ? mem[rptr_q] : 8'h00;
  assign o_rx_overrun = overrun_q;
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q, overrun_q;

  // Single-entry RX register: an unread byte wins over a new one unless consumed now
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (push_c) begin
        if (rx_valid_q && !i_rx_ready) begin
          overrun_q <= 1'b1;
        end else begin
          rx_data_q  <= rx_byte_c;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && i_rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a bit-banged SPI master drives the pins,
// expected RX bytes go into a queue and a monitor pops them as the DUT presents them.
module tb_spi_peripheral;

  localparam int H = 4;
  localparam logic [7:0] FILL_B = 8'hC3;

  logic       clk, rst;
  logic       i_sclk, i_cs_n, i_mosi;
  logic       o_miso, o_miso_oe;
  logic [7:0] i_tx_data;
  logic       i_tx_valid, o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, i_rx_ready;
  logic       i_clear;
  logic [7:0] o_transac;
  logic       o_rx_overrun, o_tx_underrun, o_abort;

  int checks = 0;
  int failures = 0;
  int n_abort = 0, n_over = 0, n_under = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_transac;

  spi_peripheral #(.FILL(FILL_B)) dut (
    .clk(clk), .rst(rst),
    .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .i_clear(i_clear), .o_transac(o_transac),
    .o_rx_overrun(o_rx_overrun), .o_tx_underrun(o_tx_underrun), .o_abort(o_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted RX byte and counts pulses
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (o_abort)       n_abort++;
      if (o_rx_overrun)  n_over++;
      if (o_tx_underrun) n_under++;
      if (o_rx_valid && i_rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected actual=%0h required=none", o_rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (o_rx_data !== e) begin
            failures++;
            $display("FAIL rx_data actual=%0h required=%0h", o_rx_data, e);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    i_cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    i_cs_n = 1'b1;
    wait_clk(2 * H);
  endtask

  // Shift n bits MSB first; returns MISO sampled at each rising edge
  task automatic shift_bits(input logic [7:0] b, input int n, input bit clr_last,
                            output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      i_mosi = b[7-i];
      wait_clk(H);
      r[7-i] = o_miso;
      i_sclk = 1'b1;
      if (clr_last && i == n - 1) i_clear = 1'b1;
      wait_clk(H);
      i_sclk = 1'b0;
      i_clear = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b, output logic [7:0] r);
    cs_low();
    shift_bits(b, 8, 1'b0, r);
    cs_high();
    exp_transac = exp_transac + 8'd1;
  endtask

  initial begin
    logic [7:0] r;
    int u0, o0, a0;
    rst = 1'b1; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    i_tx_data = 8'h00; i_tx_valid = 1'b0; i_rx_ready = 1'b1; i_clear = 1'b0;
    exp_transac = 8'd0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    check("rst_miso", o_miso, 0);
    check("rst_miso_oe", o_miso_oe, 0);
    check("rst_tx_ready", o_tx_ready, 1);
    check("rst_rx_valid", o_rx_valid, 0);
    check("rst_rx_data", o_rx_data, 0);
    check("rst_transac", o_transac, 0);

    // Held byte A5 goes out while 3C comes in
    i_tx_data = 8'hA5; i_tx_valid = 1'b1;
    wait_clk(1);
    i_tx_valid = 1'b0;
    check("tx_ready_after_accept", o_tx_ready, 0);
    exp_q.push_back(8'h3C);
    u0 = n_under;
    cs_low();
    check("miso_oe_cs_low", o_miso_oe, 1);
    check("tx_ready_after_load", o_tx_ready, 1);
    check("no_underrun_at_load", n_under - u0, 0);
    shift_bits(8'h3C, 8, 1'b0, r);
    check("miso_a5", r, 8'hA5);
    cs_high();
    exp_transac = exp_transac + 8'd1;
    check("transac_1", o_transac, exp_transac);
    check("miso_oe_cs_high", o_miso_oe, 0);

    // Empty holding register: FILL shifted, one underrun at CS fall
    exp_q.push_back(8'h5A);
    u0 = n_under;
    cs_low();
    check("underrun_at_cs_fall", n_under - u0, 1);
    shift_bits(8'h5A, 8, 1'b0, r);
    check("miso_fill", r, FILL_B);
    cs_high();
    exp_transac = exp_transac + 8'd1;
    check("transac_2", o_transac, exp_transac);

    // Consumer stalled
    i_rx_ready = 1'b0;
    o0 = n_over;
    frame(8'h11, r);
    frame(8'h22, r);
`ifdef SPI_PERIPH_RX_FIFO_EN
    frame(8'h33, r);
    frame(8'h44, r);
    frame(8'h55, r);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
`else
    exp_q.push_back(8'h11);
`endif
    check("stall_rx_valid", o_rx_valid, 1);
    check("stall_rx_data", o_rx_data, 8'h11);
    check("overrun_once", n_over - o0, 1);
    check("transac_stall", o_transac, exp_transac);
    i_rx_ready = 1'b1;
    wait_clk(8);
    check("drained_rx_valid", o_rx_valid, 0);

    // Abort after 5 bits, then a clean frame
    a0 = n_abort;
    cs_low();
    shift_bits(8'hFF, 5, 1'b0, r);
    cs_high();
    check("abort_pulse", n_abort - a0, 1);
    check("transac_after_abort", o_transac, exp_transac);
    exp_q.push_back(8'hF0);
    frame(8'hF0, r);
    check("transac_after_f0", o_transac, exp_transac);

    // Counter wrap and clear coincident with completion
    i_clear = 1'b1;
    wait_clk(1);
    i_clear = 1'b0;
    exp_transac = 8'd0;
    check("transac_cleared", o_transac, 0);
    cs_low();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = 8'(k) ^ 8'h5A;
      exp_q.push_back(b);
      shift_bits(b, 8, 1'b0, r);
      exp_transac = exp_transac + 8'd1;
      if (k == 254) check("transac_255", o_transac, 8'd255);
    end
    wait_clk(H);
    check("transac_wrap", o_transac, exp_transac);
    exp_q.push_back(8'h96);
    shift_bits(8'h96, 8, 1'b1, r);
    check("transac_clear_on_done", o_transac, 0);
    cs_high();

    // Reset mid-frame after 3 bits
    a0 = n_abort; o0 = n_over;
    cs_low();
    shift_bits(8'hFF, 3, 1'b0, r);
    rst = 1'b1;
    wait_clk(1);
    check("mid_rst_miso", o_miso, 0);
    check("mid_rst_miso_oe", o_miso_oe, 0);
    check("mid_rst_tx_ready", o_tx_ready, 1);
    check("mid_rst_rx_valid", o_rx_valid, 0);
    check("mid_rst_transac", o_transac, 0);
    check("mid_rst_abort", o_abort, 0);
    rst = 1'b0;
    exp_transac = 8'd0;
    cs_high();
    check("no_abort_after_rst", n_abort - a0, 0);
    check("no_overrun_after_rst", n_over - o0, 0);
    exp_q.push_back(8'h81);
    frame(8'h81, r);
    check("transac_after_rst", o_transac, exp_transac);

    wait_clk(10);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
